// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ requesters,
// with burst locking capped at MAX_BURST. Optional launch watchdog: define TX_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_ready,
  input  logic                   i_tx_done,
  input  logic                   i_tx_active,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  MAX_BURST_C = BC_W'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              last_q;
  logic [BC_W-1:0]   burst_cnt;

  logic [7:0]        req_bytes [NUM_REQ];
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              burst_continue;

  // The transmitter busy flag is informational only; sequencing relies on the done pulse.
  logic unused_tx_active;
  assign unused_tx_active = i_tx_active;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_bytes
    assign req_bytes[r] = i_req_data[8*r +: 8];
  end

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  // Search starts just after the last released owner, so each requester is
  // served at most once per rotation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && i_req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign burst_continue = !last_q && (burst_cnt < MAX_BURST_C);

`ifdef TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  assign o_timeout = to_flag;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign o_timeout          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= LAST_IDX;
      grant_idx   <= '0;
      last_q      <= 1'b0;
      burst_cnt   <= '0;
      o_req_ready <= '0;
      o_grant     <= '0;
      o_tx_data   <= 8'h00;
      o_tx_ready  <= 1'b0;
      o_busy      <= 1'b0;
`ifdef TX_TIMEOUT_EN
      to_cnt      <= '0;
      to_flag     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments; the pulse defaults below are overridden by
      // a later assignment in the same cycle because the last scheduled update wins.
      o_tx_ready <= 1'b0;
`ifdef TX_TIMEOUT_EN
      to_flag    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            o_grant     <= to_onehot(pick_idx);
            o_req_ready <= to_onehot(pick_idx);
            o_busy      <= 1'b1;
            state       <= S_GRANT;
          end
        end

        // Ready stays high until the owner presents a byte; a locked owner
        // keeps the grant while it catches up.
        S_GRANT: begin
          if (i_req_valid[grant_idx]) begin
            o_tx_data   <= req_bytes[grant_idx];
            last_q      <= i_req_last[grant_idx];
            burst_cnt   <= burst_cnt + BC_W'(1);
            o_req_ready <= '0;
            o_tx_ready  <= 1'b1;
            state       <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          state <= S_WAIT_DONE;
`ifdef TX_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        S_WAIT_DONE: begin
          if (i_tx_done) begin
            if (burst_continue) begin
              o_req_ready <= o_grant;
              state       <= S_GRANT;
            end else begin
              rr_ptr    <= grant_idx;
              o_grant   <= '0;
              burst_cnt <= '0;
              o_busy    <= 1'b0;
              state     <= S_IDLE;
            end
          end
`ifdef TX_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            to_flag   <= 1'b1;
            rr_ptr    <= grant_idx;
            o_grant   <= '0;
            burst_cnt <= '0;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART byte transmitter among NUM_REQ requesters. Uses round-robin arbitration with optional burst locking. Each requester presents bytes over a valid/ready handshake. The scheduler launches one byte at a time into the transmitter with a single-cycle start pulse, then waits for the transmitter's done pulse before granting again.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MAX_BURST, 16, maximum bytes one requester may send under lock before the lock is forcibly released (1..255).
TIMEOUT_CYC, 64, cycles allowed from launch to i_tx_done before abort (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
i_req_valid  in  NUM_REQ  per-requester byte valid.
i_req_data  in  8*NUM_REQ  byte for requester r in bits [8r+7:8r].
i_req_last  in  NUM_REQ  byte is the last of the requester's burst.
o_req_ready  out  NUM_REQ  one-hot accept pulse; a byte transfers on valid & ready.
o_grant  out  NUM_REQ  one-hot current owner; all zero in IDLE.
o_tx_data  out  8  byte to the transmitter; held stable from launch until done.
o_tx_ready  out  1  single-cycle start pulse to the transmitter.
i_tx_done  in  1  transmitter done pulse (one cycle).
i_tx_active  in  1  transmitter busy flag (status only, not used for sequencing).
o_busy  out  1  high whenever state != IDLE.
o_timeout  out  1  single-cycle abort flag.

Behaviour:
- Reset values:
  - o_req_ready = 0, o_grant = 0, o_tx_data = 8'h00, o_tx_ready = 0, o_busy = 0, o_timeout = 0.
  - State = IDLE, round-robin pointer = NUM_REQ-1 (so requester 0 wins first), lock = 0, burst count = 0.
- States: IDLE, GRANT, LAUNCH, WAIT_DONE. All outputs are registered.
- IDLE:
  - If any i_req_valid is set, select the first valid requester searching from pointer+1, wrapping at NUM_REQ.
  - Register o_grant and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - o_req_ready[g] = 1 for exactly this cycle.
  - If i_req_valid[g] = 1: capture the data into o_tx_data, capture i_req_last, increment the burst count, go to LAUNCH.
  - If i_req_valid[g] = 0 (locked owner not yet ready): stay in GRANT with ready held high; the owner keeps the grant.
- Requester rule: once valid is raised, valid and data stay stable until accepted.
- LAUNCH: o_tx_ready = 1 for exactly one cycle, then go to WAIT_DONE.
- Latency: valid at edge k gives ready high in cycle k+1 and o_tx_ready high in cycle k+2.
- WAIT_DONE:
  - o_tx_data is held. i_tx_done is honoured only in this state; a done pulse in any other state is ignored.
  - On i_tx_done, the lock is set when the captured last = 0 and burst count < MAX_BURST.
  - Lock set: go to GRANT with the same owner.
  - Lock clear: set pointer = g, clear o_grant and burst count, go to IDLE.
- Lock: while lock = 1, other requesters are never granted, even with valid high.
- Simultaneous valids: the round-robin order is strict. Each requester is served at most once per rotation, unless it holds a burst lock.
- Burst cap: a burst reaching MAX_BURST bytes releases the lock after that byte's done, whatever the value of last.
- Reset mid-operation:
  - Every output returns to its reset value on the next evaluation; there are no partial handshakes.
  - The transmitter shares the reset domain and is reset alongside, with polarity adapted at integration.

Optional Feature:
TX_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYC without i_tx_done: o_timeout pulses for one cycle, the lock is cleared, pointer = g, and the block returns to IDLE.
  - A late done pulse is ignored.
- Not defined: no counter is built, o_timeout is tied 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Requester 0 sends 8'hA5 with last = 1 → ready[0] one cycle, o_tx_ready pulses once with o_tx_data = A5. After done, grant = 0 and busy = 0.
- Requesters 0, 1 and 3 all valid with last = 1 → launch order 0, 1, 3. Then requester 0 again → order 0 (pointer wraps after 3).
- Requester 2 bursts 8'h10, 8'h11, 8'h12 (last on 12) while requester 1 is valid → all three sent back-to-back, then requester 1 is granted.
- Requester 1 bursts 20 bytes with last = 0 and MAX_BURST = 16 → the lock releases after byte 16, a competing requester 2 is served, and requester 1 resumes later.
- i_tx_done pulsed during IDLE and LAUNCH → no state change, no extra o_tx_ready. Reset asserted during WAIT_DONE → all outputs 0 in the same cycle and pointer restored.
- With TX_TIMEOUT_EN and TIMEOUT_CYC = 64, done withheld → o_timeout pulses exactly 64 cycles after entering WAIT_DONE, then IDLE. A late done is ignored.
